// File: rtl/sockit_spi_slave.sv
// SPI slave for 8-bit single-IO frames, oversampling the bus pins in the clk domain.
// Receives MOSI into rx_dat/rx_vld and serialises the tx_dat/tx_vld stream onto MISO.
module sockit_spi_slave #(
  parameter int SDW = 8,
  parameter int SDL = 3,
  parameter int SYN = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_pol,
  input  logic           cfg_pha,
  input  logic           cfg_dir,
  input  logic           spi_sclk,
  input  logic           spi_ss_n,
  input  logic           spi_mosi,
  output logic           spi_miso,
  output logic           spi_miso_oe,
  input  logic [SDW-1:0] tx_dat,
  input  logic           tx_vld,
  output logic           tx_rdy,
  output logic [SDW-1:0] rx_dat,
  output logic           rx_vld,
  input  logic           rx_rdy,
  output logic           sts_act,
  output logic           sts_unf,
  output logic           sts_ovf
);

  logic [SYN-1:0] sclk_sync, ss_sync, mosi_sync;
  logic           s_sclk, s_ss, s_mosi;
  logic           sclk_d, ss_d;
  logic           live, armed;
  logic           pol_q, pha_q, dir_q;
  logic [SDW-1:0] rx_sh, tx_sh, rx_next;
  logic [SDL-1:0] rx_cnt, tx_cnt;
  logic           sel_on, sel_off, edge_ok, lead, trail, smp, sft;
  logic           rx_done, load, load_dir;

  assign s_sclk = sclk_sync[SYN-1];
  assign s_ss   = ss_sync[SYN-1];
  assign s_mosi = mosi_sync[SYN-1];

  // armed guards against treating a select held low across reset as a new assert
  assign sel_on  = armed & ss_d & ~s_ss & ~sts_act;
  assign sel_off = sts_act & s_ss;
  assign edge_ok = sts_act & ~s_ss;
  assign lead    = edge_ok & (sclk_d == pol_q) & (s_sclk != pol_q);
  assign trail   = edge_ok & (sclk_d != pol_q) & (s_sclk == pol_q);
  assign smp     = pha_q ? trail : lead;
  assign sft     = pha_q ? lead : trail;

  assign rx_next = dir_q ? {rx_sh[SDW-2:0], s_mosi} : {s_mosi, rx_sh[SDW-1:1]};
  assign rx_done = smp & (rx_cnt == SDL'(SDW-1));

  // pha=0 preloads at select assert and reloads after the last shift; pha=1 loads on the first shift
  assign load     = ~rst & ((sel_on & ~cfg_pha) |
                            (sft & (tx_cnt == (pha_q ? '0 : SDL'(SDW-1)))));
  assign load_dir = sel_on ? cfg_dir : dir_q;
  assign tx_rdy   = load & tx_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync   <= '0;
      ss_sync     <= '1;
      mosi_sync   <= '1;
      sclk_d      <= 1'b0;
      ss_d        <= 1'b1;
      live        <= 1'b0;
      armed       <= 1'b0;
      pol_q       <= 1'b0;
      pha_q       <= 1'b0;
      dir_q       <= 1'b0;
      rx_sh       <= '0;
      tx_sh       <= '1;
      rx_cnt      <= '0;
      tx_cnt      <= '0;
      rx_dat      <= '0;
      rx_vld      <= 1'b0;
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
      sts_act     <= 1'b0;
      sts_unf     <= 1'b0;
      sts_ovf     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYN-2:0], spi_sclk};
      ss_sync   <= {ss_sync[SYN-2:0], spi_ss_n};
      mosi_sync <= {mosi_sync[SYN-2:0], spi_mosi};
      sclk_d    <= s_sclk;
      ss_d      <= s_ss;
      live      <= 1'b1;
      if (live & ss_sync[0]) armed <= 1'b1;
      sts_unf   <= 1'b0;
      sts_ovf   <= 1'b0;

      if (sel_on) begin
        sts_act     <= 1'b1;
        spi_miso_oe <= 1'b1;
        pol_q       <= cfg_pol;
        pha_q       <= cfg_pha;
        dir_q       <= cfg_dir;
        rx_cnt      <= '0;
        tx_cnt      <= '0;
      end
      if (sel_off) begin
        sts_act     <= 1'b0;
        spi_miso_oe <= 1'b0;
        spi_miso    <= 1'b1;
        rx_cnt      <= '0;
        tx_cnt      <= '0;
      end

      if (smp) begin
        rx_sh  <= rx_next;
        rx_cnt <= rx_cnt + 1'b1;
      end
      if (rx_done) begin
        if (~rx_vld | rx_rdy) begin
          rx_dat <= rx_next;
          rx_vld <= 1'b1;
        end else begin
          sts_ovf <= 1'b1;
        end
      end else if (rx_vld & rx_rdy) begin
        rx_vld <= 1'b0;
      end

      if (load) begin
        tx_sh    <= tx_vld ? tx_dat : '1;
        spi_miso <= tx_vld ? (load_dir ? tx_dat[SDW-1] : tx_dat[0]) : 1'b1;
        sts_unf  <= ~tx_vld;
      end else if (sft) begin
        if (dir_q) begin
          tx_sh    <= {tx_sh[SDW-2:0], 1'b1};
          spi_miso <= tx_sh[SDW-2];
        end else begin
          tx_sh    <= {1'b1, tx_sh[SDW-1:1]};
          spi_miso <= tx_sh[1];
        end
      end
      if (sft) tx_cnt <= tx_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sockit_spi_slave.sv
// Bench for sockit_spi_slave: a bit-banged SPI master drives frames while a
// byte-level model predicts MISO bytes, received bytes and handshake/status pulse counts.
module tb_sockit_spi_slave;

  localparam int H = 6;

  logic       clk, rst;
  logic       cfg_pol, cfg_pha, cfg_dir;
  logic       spi_sclk, spi_ss_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_dat;
  logic       tx_vld, tx_rdy;
  logic [7:0] rx_dat;
  logic       rx_vld, rx_rdy;
  logic       sts_act, sts_unf, sts_ovf;

  logic [7:0] tx_q[$], mosi_q[$], miso_got[$], rx_got[$];
  int rdy_cnt, unf_cnt, ovf_cnt;
  int vectors, errs;

  sockit_spi_slave #(.SDW(8), .SDL(3), .SYN(2)) dut (
    .clk(clk), .rst(rst),
    .cfg_pol(cfg_pol), .cfg_pha(cfg_pha), .cfg_dir(cfg_dir),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_dat(tx_dat), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .rx_dat(rx_dat), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
    .sts_act(sts_act), .sts_unf(sts_unf), .sts_ovf(sts_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor pulses at the falling edge; advance the tx stream only after the consuming rising edge
  initial begin
    bit pop;
    tx_vld = 1'b0;
    tx_dat = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_rdy) rdy_cnt++;
      if (sts_unf) unf_cnt++;
      if (sts_ovf) ovf_cnt++;
      if (rx_vld && rx_rdy) rx_got.push_back(rx_dat);
      pop = tx_rdy;
      @(posedge clk);
      #1;
      if (pop && tx_q.size() > 0) void'(tx_q.pop_front());
      tx_vld = (tx_q.size() > 0);
      tx_dat = tx_vld ? tx_q[0] : 8'h00;
    end
  end

  task automatic waitH();
    repeat (H) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit pol, input bit pha, input bit dir, input int nbits);
    logic [7:0] mb, rb;
    cfg_pol  = pol;
    cfg_pha  = pha;
    cfg_dir  = dir;
    spi_sclk = pol;
    rb = 8'h00;
    miso_got.delete();
    waitH();
    spi_ss_n = 1'b0;
    waitH();
    for (int i = 0; i < nbits; i++) begin
      int k, pos;
      k   = i % 8;
      pos = dir ? 7 - k : k;
      mb  = mosi_q[i / 8];
      if (i == 0) begin
        checkOutput("act_in_frame", 32'(sts_act), 32'd1);
        checkOutput("oe_in_frame", 32'(spi_miso_oe), 32'd1);
      end
      if (!pha) begin
        spi_mosi = mb[pos];
        waitH();
        rb[pos]  = spi_miso;
        spi_sclk = ~pol;
        waitH();
        spi_sclk = pol;
      end else begin
        spi_sclk = ~pol;
        spi_mosi = mb[pos];
        waitH();
        rb[pos]  = spi_miso;
        spi_sclk = pol;
        waitH();
      end
      if (k == 7) miso_got.push_back(rb);
    end
    waitH();
    spi_ss_n = 1'b1;
    waitH();
    waitH();
  endtask

  // Byte-level expectation: count loads from the mode, fill them from tx_q, then all-ones
  task automatic runCheck(input bit pol, input bit pha, input bit dir, input int nbits);
    logic [7:0] exp_tx[$];
    int loads, nq, nb, took, r0, u0;
    exp_tx = tx_q;
    nq     = tx_q.size();
    nb     = nbits / 8;
    loads  = pha ? (nbits + 7) / 8 : 1 + nbits / 8;
    took   = (nq < loads) ? nq : loads;
    r0     = rdy_cnt;
    u0     = unf_cnt;
    rx_got.delete();
    applyStimulus(pol, pha, dir, nbits);
    for (int k = 0; k < nb; k++)
      checkOutput("miso_byte", 32'(miso_got[k]), 32'((k < nq) ? exp_tx[k] : 8'hFF));
    checkOutput("tx_rdy_pulses", rdy_cnt - r0, took);
    checkOutput("unf_pulses", unf_cnt - u0, loads - took);
    checkOutput("rx_count", rx_got.size(), nb);
    for (int k = 0; k < nb && k < rx_got.size(); k++)
      checkOutput("rx_byte", 32'(rx_got[k]), 32'(mosi_q[k]));
    checkOutput("oe_idle", 32'(spi_miso_oe), 32'd0);
    checkOutput("miso_idle", 32'(spi_miso), 32'd1);
    checkOutput("act_idle", 32'(sts_act), 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_miso"}, 32'(spi_miso), 32'd1);
    checkOutput({tag, "_oe"}, 32'(spi_miso_oe), 32'd0);
    checkOutput({tag, "_tx_rdy"}, 32'(tx_rdy), 32'd0);
    checkOutput({tag, "_rx_dat"}, 32'(rx_dat), 32'd0);
    checkOutput({tag, "_rx_vld"}, 32'(rx_vld), 32'd0);
    checkOutput({tag, "_act"}, 32'(sts_act), 32'd0);
    checkOutput({tag, "_unf"}, 32'(sts_unf), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(sts_ovf), 32'd0);
  endtask

  initial begin
    int o0;
    vectors = 0; errs = 0;
    rdy_cnt = 0; unf_cnt = 0; ovf_cnt = 0;
    rst = 1'b1;
    cfg_pol = 1'b0; cfg_pha = 1'b0; cfg_dir = 1'b1;
    spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b1;
    rx_rdy = 1'b1;
    repeat (4) @(negedge clk);
    checkResetState("rst");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkResetState("post_rst");

    $display("[TB] mode 0 MSB-first, tx A5 rx 3C");
    tx_q = '{8'hA5};
    mosi_q = '{8'h3C};
    runCheck(1'b0, 1'b0, 1'b1, 8);

    $display("[TB] mode 3 LSB-first burst");
    tx_q = '{8'h01, 8'h80, 8'hFF};
    mosi_q = '{8'h55, 8'hAA, 8'h0F};
    runCheck(1'b1, 1'b1, 1'b0, 24);

    $display("[TB] transmit underrun");
    tx_q.delete();
    mosi_q = '{8'hC3};
    runCheck(1'b0, 1'b1, 1'b1, 8);

    $display("[TB] receive overrun");
    @(posedge clk); #1 rx_rdy = 1'b0;
    tx_q.delete();
    mosi_q = '{8'h11, 8'h22};
    o0 = ovf_cnt;
    rx_got.delete();
    applyStimulus(1'b0, 1'b0, 1'b1, 16);
    checkOutput("ovf_rx_vld", 32'(rx_vld), 32'd1);
    checkOutput("ovf_rx_dat", 32'(rx_dat), 32'h11);
    checkOutput("ovf_pulses", ovf_cnt - o0, 1);
    checkOutput("ovf_no_accept", rx_got.size(), 0);
    @(posedge clk); #1 rx_rdy = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("ovf_drain_count", rx_got.size(), 1);
    if (rx_got.size() > 0) checkOutput("ovf_drain_byte", 32'(rx_got[0]), 32'h11);
    checkOutput("ovf_drain_vld", 32'(rx_vld), 32'd0);

    $display("[TB] partial frame then 0x96");
    tx_q = '{8'h3A};
    mosi_q = '{8'hE7};
    runCheck(1'b0, 1'b0, 1'b1, 5);
    tx_q = '{8'h69};
    mosi_q = '{8'h96};
    runCheck(1'b0, 1'b0, 1'b1, 8);

    $display("[TB] reset mid-frame");
    tx_q.delete();
    rx_got.delete();
    cfg_pol = 1'b0; cfg_pha = 1'b0; cfg_dir = 1'b1;
    spi_sclk = 1'b0;
    waitH();
    spi_ss_n = 1'b0;
    waitH();
    for (int i = 0; i < 3; i++) begin
      spi_mosi = 1'b1; waitH(); spi_sclk = 1'b1; waitH(); spi_sclk = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkResetState("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      spi_mosi = i[0]; waitH(); spi_sclk = 1'b1; waitH(); spi_sclk = 1'b0;
    end
    waitH();
    checkOutput("rst_ignore_act", 32'(sts_act), 32'd0);
    checkOutput("rst_ignore_oe", 32'(spi_miso_oe), 32'd0);
    checkOutput("rst_ignore_rx", rx_got.size(), 0);
    checkOutput("rst_ignore_vld", 32'(rx_vld), 32'd0);
    spi_ss_n = 1'b1;
    waitH();
    tx_q = '{8'h5A};
    mosi_q = '{8'h42};
    runCheck(1'b0, 1'b0, 1'b1, 8);

    $display("[TB] random frames");
    for (int f = 0; f < 16; f++) begin
      bit p, h, d;
      int nb, ld, nq;
      p  = 1'($urandom_range(0, 1));
      h  = 1'($urandom_range(0, 1));
      d  = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      mosi_q.delete();
      for (int j = 0; j < nb; j++) mosi_q.push_back(8'($urandom_range(0, 255)));
      ld = h ? nb : nb + 1;
      nq = $urandom_range(0, ld);
      tx_q.delete();
      for (int j = 0; j < nq; j++) tx_q.push_back(8'($urandom_range(0, 255)));
      runCheck(p, h, d, nb * 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/sockit_spi_slave.md
Name: sockit_spi_slave

Overview:
- SPI slave (responder), standard single-IO mode, 8-bit frames; the bus-side counterpart of the sockit_spi master.
- Oversamples the external SPI pins in the system clock domain.
- Deserialises MOSI into a receive stream and serialises a transmit stream onto MISO.
- Clock polarity, clock phase and shift direction use the same meaning as the master configuration fields pol, pha and dir.

Parameters:
- SDW, 8: serial data word width in bits.
- SDL, 3: log2(SDW); width of the bit counter.
- SYN, 2: number of synchroniser flops on spi_sclk, spi_ss_n and spi_mosi (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 4x the spi_sclk frequency.
- rst  input  1  reset, synchronous, active-high.
- cfg_pol  input  1  clock polarity (idle level of spi_sclk).
- cfg_pha  input  1  clock phase (0: sample on leading edge, 1: sample on trailing edge).
- cfg_dir  input  1  shift direction (0: LSB first, 1: MSB first).
- spi_sclk  input  1  SPI clock, asynchronous to clk.
- spi_ss_n  input  1  slave select, active-low, asynchronous to clk.
- spi_mosi  input  1  serial data in.
- spi_miso  output  1  serial data out.
- spi_miso_oe  output  1  MISO output enable.
- tx_dat  input  SDW  transmit byte.
- tx_vld  input  1  transmit byte valid.
- tx_rdy  output  1  transmit byte consumed.
- rx_dat  output  SDW  received byte.
- rx_vld  output  1  received byte valid.
- rx_rdy  input  1  received byte accepted.
- sts_act  output  1  select active (synchronised).
- sts_unf  output  1  one-cycle pulse: transmit underrun.
- sts_ovf  output  1  one-cycle pulse: receive overrun.

Behaviour:
- Reset values: spi_miso=1, spi_miso_oe=0, tx_rdy=0, rx_dat=0, rx_vld=0, sts_act=0, sts_unf=0, sts_ovf=0, bit counters=0, synchronisers=idle (ss_n=1, sclk=0).
- Reset mid-frame aborts the frame. After reset, the slave ignores the bus until spi_ss_n is seen high, then low again.
- Synchronisation: each pin passes through SYN flops. Edges are detected by comparing the synchronised value with a one-cycle-delayed copy.
- Select and configuration:
  - Select assert = synchronised ss_n falling. On the assert cycle, cfg_pol, cfg_pha and cfg_dir are latched. Changes to cfg_* during an active select have no effect.
  - While select is active: sts_act=1, spi_miso_oe=1.
- Edge roles:
  - Leading edge = synchronised sclk leaving cfg_pol; trailing edge = returning to cfg_pol.
  - Sample edge = leading if pha=0, trailing if pha=1. Shift edge = the other edge.
  - Edges are ignored while select is inactive.
- Receive:
  - On each sample edge, the synchronised mosi value is shifted in (into bit 0 moving up if dir=1, into bit SDW-1 moving down if dir=0) and the rx bit counter increments (wraps at SDW).
  - On the SDW-th sample edge: if rx_vld=0 or rx_rdy=1 in that cycle, rx_dat is loaded with the completed byte and rx_vld=1 on the next cycle. Otherwise the new byte is dropped, rx_dat is kept, and sts_ovf pulses.
  - rx_vld clears on the cycle after rx_vld&rx_rdy unless a new byte loads in the same cycle (load wins, rx_vld stays 1).
- Transmit:
  - A load takes the next byte into the tx shift register and drives its first bit (MSB if dir=1, LSB if dir=0) onto spi_miso.
  - pha=0: load at select assert and at every SDW-th shift edge.
  - pha=1: load at the shift edge where the tx bit counter is 0 (1st, SDW+1th, ...).
  - All other shift edges drive the next bit.
  - On load: if tx_vld=1, tx_dat is taken and tx_rdy pulses for exactly that cycle. If tx_vld=0, all-ones are sent and sts_unf pulses. tx_rdy is never asserted outside a load.
  - spi_miso updates on the clock after the shift-edge detection cycle.
- Select deassert: spi_miso_oe=0, spi_miso=1, sts_act=0 on the next cycle. Both bit counters clear. A partial rx byte is discarded (no rx_vld, no ovf). A partially sent tx byte is dropped; no tx_rdy for it.
- Simultaneous select deassert and sample edge: deassert wins, and the edge is ignored.
- Latency: pin edge to internal action = SYN+1 clk cycles. MISO valid no later than SYN+2 clk cycles after the shift pin edge.

Test Plan:
- Mode 0, dir=1, tx_vld with tx_dat=0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_dat=0x3C with one rx_vld; one tx_rdy pulse at select assert.
- Mode 3 (pol=1,pha=1), dir=0, 3-byte burst tx 0x01,0x80,0xFF, rx 0x55,0xAA,0x0F -> MISO LSB-first matches; three rx_vld bytes in order; tx_rdy pulses on 1st, 9th and 17th shift edges.
- tx_vld=0 at a load -> MISO sends 0xFF; sts_unf pulses once; tx_rdy stays 0.
- rx_rdy held 0 across two received bytes 0x11,0x22 -> rx_dat stays 0x11, rx_vld=1, sts_ovf pulses once on the 2nd byte's 8th sample.
- Select deassert after 5 bits, then a new frame receiving 0x96 -> no rx_vld for the partial frame; the next frame yields rx_dat=0x96 with correct bit alignment.
- rst asserted mid-byte, released while ss_n low -> all outputs at reset values; no rx_vld until ss_n goes high then low, after which 0x42 is received correctly.
